// File: rtl/crc16_frame_tx.sv
// Transmit-path frame sequencer: forwards payload bytes, appends CRC-16-CCITT (hi, lo), reseeds per frame.
// One-cycle registered latency; single output stage, s_ready drops whenever the output slot is occupied and stalled.
module crc16_frame_tx #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
  parameter int          LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic [15:0]      crc_cur,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len
);

  typedef enum logic [1:0] {PAYLOAD, CRC_HI, CRC_LO} state_t;

  state_t           state, state_nxt;
  logic [15:0]      crc, crc_nxt;
  logic [LEN_W-1:0] count, count_nxt, frame_len_nxt;
  logic [7:0]       m_data_nxt;
  logic             m_valid_nxt, m_last_nxt, frame_done_nxt;
  logic             ofree, accept;

  // Unrolled MSB-first division by 0x1021; equivalent to the byte-table update.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  assign ofree   = !m_valid || m_ready;
  assign s_ready = (state == PAYLOAD) && ofree;
  assign accept  = s_valid && s_ready;
  assign crc_cur = crc;

  always_comb begin
    state_nxt      = state;
    crc_nxt        = crc;
    count_nxt      = count;
    frame_len_nxt  = frame_len;
    m_valid_nxt    = m_valid;
    m_data_nxt     = m_data;
    m_last_nxt     = m_last;
    frame_done_nxt = 1'b0;
    case (state)
      PAYLOAD: begin
        if (accept) begin
          m_data_nxt  = s_data;
          m_valid_nxt = 1'b1;
          m_last_nxt  = 1'b0;
          crc_nxt     = crc_byte(crc, s_data);
          count_nxt   = (&count) ? count : count + LEN_W'(1);
          if (s_last) state_nxt = CRC_HI;
        end else if (m_ready) begin
          m_valid_nxt = 1'b0;
        end
      end
      CRC_HI: begin
        if (ofree) begin
          m_data_nxt  = crc[15:8];
          m_valid_nxt = 1'b1;
          m_last_nxt  = 1'b0;
          state_nxt   = CRC_LO;
        end
      end
      CRC_LO: begin
        if (ofree) begin
          m_data_nxt     = crc[7:0];
          m_valid_nxt    = 1'b1;
          m_last_nxt     = 1'b1;
          frame_done_nxt = 1'b1;
          frame_len_nxt  = count;
          count_nxt      = '0;
          crc_nxt        = CRC_INIT;
          state_nxt      = PAYLOAD;
        end
      end
      default: state_nxt = PAYLOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PAYLOAD;
      crc        <= CRC_INIT;
      count      <= '0;
      frame_len  <= '0;
      m_valid    <= 1'b0;
      m_data     <= 8'h00;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      crc        <= crc_nxt;
      count      <= count_nxt;
      frame_len  <= frame_len_nxt;
      m_valid    <= m_valid_nxt;
      m_data     <= m_data_nxt;
      m_last     <= m_last_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Randomized bench for crc16_frame_tx against a bit-serial CRC reference and an expected-beat queue.
module tb_crc16_frame_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_valid, s_ready, s_last, m_valid, m_ready, m_last, frame_done;
  logic [7:0]  s_data, m_data;
  logic [15:0] crc_cur, frame_len;

  crc16_frame_tx #(.CRC_INIT(16'hFFFF), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .crc_cur(crc_cur), .frame_done(frame_done), .frame_len(frame_len)
  );

  typedef logic [7:0] bq_t[$];

  logic [8:0]  in_q[$];
  logic [8:0]  exp_q[$];
  int          len_q[$];
  logic [15:0] crc_q[$];

  int n_vec = 0, n_err = 0;
  int vpct = 100, rpct = 100, stall_cnt = 0;
  bit arm29 = 0, prev_stall = 0, pend_crc = 0;
  logic [8:0]  prev_beat = '0;
  logic [15:0] pend_val = '0;
  int acc_cnt = 0, done_cnt = 0, beat_cnt = 0, srlow_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial long division of the whole message, seed 0xFFFF, no final XOR.
  function automatic logic [15:0] ref_crc(input bq_t m);
    logic [15:0] r = 16'hFFFF;
    logic        fb;
    foreach (m[i])
      for (int b = 7; b >= 0; b--) begin
        fb = r[15] ^ m[i][b];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    return r;
  endfunction

  task automatic push_frame(input bq_t m, input logic [15:0] c);
    foreach (m[i]) begin
      in_q.push_back({(i == m.size() - 1), m[i]});
      exp_q.push_back({1'b0, m[i]});
    end
    exp_q.push_back({1'b0, c[15:8]});
    exp_q.push_back({1'b1, c[7:0]});
    len_q.push_back(m.size());
    crc_q.push_back(c);
  endtask

  function automatic bq_t digits();
    bq_t m;
    for (int i = 0; i < 9; i++) m.push_back(8'(8'h31 + i));
    return m;
  endfunction

  task automatic cycle();
    bit          acc;
    logic [31:0] e;
    @(negedge clk);
    if (pend_crc) begin
      chk("crc_cur_after_last", crc_cur, pend_val);
      pend_crc = 0;
    end
    if (prev_stall) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_beat", {m_last, m_data}, prev_beat);
    end
    if (m_valid && !m_ready) chk("stalled_s_ready", s_ready, 0);
    if (!s_ready) srlow_cnt++;
    if (m_valid && m_ready) begin
      beat_cnt++;
      e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
      chk("out_beat", {m_last, m_data}, e);
    end
    if (frame_done) begin
      done_cnt++;
      chk("done_on_last", m_valid && m_last, 1);
      chk("reseed", crc_cur, 16'hFFFF);
      e = (len_q.size() > 0) ? 32'(len_q.pop_front()) : 32'hDEAD_BEEF;
      chk("frame_len", frame_len, e);
    end
    acc = s_valid && s_ready;
    if (acc) begin
      acc_cnt++;
      if (s_last) begin
        pend_crc = 1;
        pend_val = (crc_q.size() > 0) ? crc_q.pop_front() : 16'h0;
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_beat  = {m_last, m_data};

    @(posedge clk);
    #1;
    if (acc && in_q.size() > 0) void'(in_q.pop_front());
    if (arm29 && m_valid && m_data == 8'h29 && !m_last) begin
      stall_cnt = 5;
      arm29     = 0;
    end
    if (stall_cnt > 0) begin
      m_ready = 1'b0;
      stall_cnt--;
    end else begin
      m_ready = ($urandom_range(0, 99) < rpct);
    end
    s_valid = (in_q.size() > 0) && ($urandom_range(0, 99) < vpct);
    if (s_valid) {s_last, s_data} = in_q[0];
    else         {s_last, s_data} = 9'($urandom);
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", in_q.size() + exp_q.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_crc_cur"}, crc_cur, 16'hFFFF);
    chk({tag, "_frame_len"}, frame_len, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_s_ready"}, s_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t m;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: "123456789" at full rate
    done_cnt = 0;
    push_frame(digits(), 16'h29B1);
    run_idle(100);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_frame_len", frame_len, 9);
    chk("t1_crc_cur", crc_cur, 16'hFFFF);

    // 2: single zero byte
    m = {8'h00};
    push_frame(m, 16'hE1F0);
    run_idle(50);
    chk("t2_frame_len", frame_len, 1);

    // 3: downstream stall while the CRC high byte is presented
    arm29 = 1;
    push_frame(digits(), 16'h29B1);
    run_idle(100);
    chk("t3_stall_hit", arm29, 0);

    // 4: back-to-back frames with s_valid held high
    srlow_cnt = 0; beat_cnt = 0;
    push_frame(digits(), 16'h29B1);
    push_frame(digits(), 16'h29B1);
    run_idle(200);
    chk("t4_s_ready_low", srlow_cnt, 4);
    chk("t4_beats", beat_cnt, 22);

    // 5: reset mid-frame discards the partial frame
    acc_cnt = 0;
    push_frame(digits(), 16'h29B1);
    for (int k = 0; k < 50 && acc_cnt < 4; k++) cycle();
    chk("t5_partial_accepts", acc_cnt, 4);
    rst = 1'b1;
    in_q.delete();
    cycle();
    rst = 1'b0;
    exp_q.delete(); len_q.delete(); crc_q.delete();
    pend_crc = 0; prev_stall = 0;
    @(negedge clk);
    reset_checks("t5_reset");
    push_frame(digits(), 16'h29B1);
    run_idle(100);
    chk("t5_frame_len", frame_len, 9);

    // 6: random frames with random valid/ready
    done_cnt = 0;
    vpct = 70; rpct = 60;
    for (int f = 0; f < 1000; f++) begin
      m = {};
      for (int i = 0, n = $urandom_range(1, 8); i < n; i++) m.push_back(8'($urandom));
      push_frame(m, ref_crc(m));
    end
    run_idle(60000);
    chk("t6_frames_done", done_cnt, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crc16_frame_tx.md
Name: crc16_frame_tx

Overview:
Frame-level sequencer for the CRC-16-CCITT byte datapath on the transmit path. It accepts a payload byte stream with a valid/ready handshake and updates a running CRC one byte per accepted beat. It forwards each byte unchanged and appends the two CRC bytes, high then low, after the last payload byte. It sits between the packet source and the serializer and reseeds the CRC itself at every frame boundary, so no reset pulse is needed between frames.

Parameters:
CRC_INIT, 16'hFFFF, seed loaded at reset and after every appended CRC.
LEN_W, 16, width of the payload byte counter and frame_len.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
s_valid  in  1  payload byte valid.
s_ready  out  1  block accepts payload byte this cycle.
s_data  in  8  payload byte.
s_last  in  1  marks final payload byte of frame.
m_valid  out  1  output byte valid (registered).
m_ready  in  1  downstream accepts output byte.
m_data  out  8  output byte (registered).
m_last  out  1  marks CRC low byte, the final byte of frame (registered).
crc_cur  out  16  running CRC register (debug/status).
frame_done  out  1  one-cycle pulse when the CRC low byte is loaded into the output register.
frame_len  out  LEN_W  payload byte count of the most recently completed frame.

Behaviour:
- Reset (rst=1 at clk edge) state and outputs:
  - state=PAYLOAD, m_valid=0, m_data=0, m_last=0.
  - crc=CRC_INIT, internal count=0, frame_len=0, frame_done=0.
- Reset wins over every other event. A partial frame is discarded and no CRC is emitted for it.
- CRC arithmetic is CRC-16-CCITT: polynomial 0x1021, MSB-first, no reflection, no final XOR.
  - Byte update: crc_next = {crc[7:0],8'h00} ^ T(crc[15:8]^d), where T is the 0x1021 byte table.
  - Implement it as a combinational XOR network internal to this block.
- Output slot free: ofree = !m_valid || m_ready. The output is a single registered stage with no skid buffer.
- s_ready = (state==PAYLOAD) && ofree. It is combinational from state, m_valid and m_ready, and is never driven from s_valid.
- State PAYLOAD, on accept (s_valid && s_ready):
  - m_data<=s_data, m_valid<=1, m_last<=0, crc<=crc_next(crc,s_data).
  - count<=count+1, saturating at all-ones.
  - If s_last=1, go to CRC_HI. Otherwise stay in PAYLOAD.
- State PAYLOAD, no accept: if m_ready=1, m_valid<=0; otherwise hold.
- State CRC_HI, when ofree:
  - m_data<=crc[15:8], m_valid<=1, m_last<=0, go to CRC_LO.
  - The crc register holds its value.
- State CRC_HI, not ofree: hold everything.
- State CRC_LO, when ofree:
  - m_data<=crc[7:0], m_valid<=1, m_last<=1.
  - frame_done<=1 for exactly one cycle, frame_len<=count.
  - count<=0, crc<=CRC_INIT, go to PAYLOAD.
- State CRC_LO, not ofree: hold everything.
- While m_valid=1 and m_ready=0, m_data and m_last hold stable. The output never drops valid without a handshake.
- Latency: an accepted input byte appears on m_data on the next cycle.
- Throughput with m_ready held at 1:
  - One payload byte per cycle.
  - s_ready is low for exactly 2 cycles per frame (CRC_HI, CRC_LO).
  - Frame of N payload bytes occupies N+2 output beats.
- crc_cur reflects the register directly. After the final payload accept it equals the frame CRC until the reseed in CRC_LO.
- Zero-length frames are not representable: s_last always accompanies a data byte.
- s_data and s_last are ignored when s_valid=0 or s_ready=0.

Test Plan:
1. Reset, then "123456789" (0x31..0x39, s_last on 0x39) with m_ready=1 -> output 31..39, 0x29, 0xB1. m_last only on 0xB1, frame_done pulses once, frame_len=9, crc_cur=16'hFFFF afterwards.
2. Single byte 0x00 with s_last=1 -> output 0x00, 0xE1, 0xF0 with m_last on 0xF0, frame_len=1.
3. Frame 1 of test 1 with m_ready deasserted for 5 cycles while 0x29 is presented -> m_data stays 0x29 and m_valid stays 1 throughout. s_ready=0, no byte lost or duplicated, final output identical to test 1.
4. Two back-to-back "123456789" frames with s_valid held high -> both frames end with 0x29,0xB1 (reseed verified). s_ready low exactly 2 cycles between frames, 22 output beats total.
5. Assert rst for one cycle after 4 payload bytes of a frame -> m_valid=0 next cycle, no CRC emitted. A following "123456789" frame still yields 0x29B1 and frame_len=9.
6. Random m_ready/s_valid toggling over 1000 random frames against a reference CRC model -> every frame's appended CRC and frame_len match, and every beat satisfies the hold-until-accepted rule.
